// File: rtl/sram_sp_bwe_clr_pkg.sv
// Shared types and helpers for the single-port byte-write SRAM with
// power-on clear.
package sram_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // width of the data slice covered by one write-mask bit
  function automatic int grp_w(input int bits, input int mask_w);
    return bits / mask_w;
  endfunction
endpackage

// File: rtl/sram_sp_bwe_clr_if.sv
// Request/response bundle of the SRAM; the requester holds the master side.
interface sram_sp_bwe_clr_if #(
  parameter int BITS   = 128,
  parameter int ADDR_W = 3,
  parameter int MASK_W = 16
);
  logic              CEB;
  logic              WEB;
  logic [ADDR_W-1:0] A;
  logic [BITS-1:0]   D;
  logic [MASK_W-1:0] BWEB;
  logic [BITS-1:0]   Q;
  logic              QVLD;
  logic              BUSY;

  modport master (output CEB, WEB, A, D, BWEB, input  Q, QVLD, BUSY);
  modport slave  (input  CEB, WEB, A, D, BWEB, output Q, QVLD, BUSY);
endinterface

// File: rtl/sram_sp_bwe_clr_clear_fsm.sv
// Post-reset clear sequencer: walks every word once and reports BUSY until done.
import sram_pkg::*;

module sram_clear_fsm #(
  parameter int DEPTH      = 8,
  parameter int CLR_ON_RST = 1,
  parameter int CNT_W      = 3
) (
  input  logic             CLK,
  input  logic             RSTB,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [CNT_W-1:0] o_clr_addr
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  clr_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_DONE;
          r_cnt   <= '0;
        end
        ST_CLEAR: begin
          if (r_cnt == LAST) r_state <= ST_DONE;
          else               r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= ST_DONE;
      endcase
    end
  end

  // IDLE reports busy too so requests are blocked from reset until the walk ends
  assign o_busy     = (r_state == ST_CLEAR) || ((r_state == ST_IDLE) && (CLR_ON_RST != 0));
  assign o_clr_we   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt;
endmodule

// File: rtl/sram_sp_bwe_clr.sv
// Single-port SRAM with per-group write mask, 1/2-cycle read latency and an
// optional zero-fill after reset.
import sram_pkg::*;

module sram_sp_bwe_clr #(
  parameter int BITS       = 128,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int MASK_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                CLK,
  input  logic                RSTB,
  sram_sp_bwe_clr_if.slave    bus
);
  localparam int GW    = grp_w(BITS, MASK_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [BITS-1:0] r_mem [DEPTH];

  logic             w_busy, w_clr_we;
  logic [IDX_W-1:0] w_clr_addr, w_idx;
  logic             w_req, w_wr, w_rd, w_in_rng;
  logic [BITS-1:0]  w_rd_data;

  logic [RD_LAT:1]  r_vld_pipe;
  logic [BITS-1:0]  r_dat_pipe [RD_LAT:1];

  sram_clear_fsm #(
    .DEPTH(DEPTH), .CLR_ON_RST(CLR_ON_RST), .CNT_W(IDX_W)
  ) u_clr (
    .CLK(CLK), .RSTB(RSTB),
    .o_busy(w_busy), .o_clr_we(w_clr_we), .o_clr_addr(w_clr_addr)
  );

  assign w_req     = !bus.CEB && !w_busy;
  assign w_wr      = w_req && !bus.WEB;
  assign w_rd      = w_req &&  bus.WEB;
  assign w_in_rng  = {1'b0, bus.A} < DEPTH_A;
  assign w_idx     = bus.A[IDX_W-1:0];
  assign w_rd_data = w_in_rng ? r_mem[w_idx] : '0;

  // array has no reset; the clear walk is the only way it gets zeroed
  always_ff @(posedge CLK) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr && w_in_rng) begin
      for (int g = 0; g < MASK_W; g++)
        if (!bus.BWEB[g]) r_mem[w_idx][g*GW +: GW] <= bus.D[g*GW +: GW];
    end
  end

  // each stage only loads on a valid, so Q holds between reads
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_vld_pipe <= '0;
      for (int s = 1; s <= RD_LAT; s++) r_dat_pipe[s] <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd;
      if (w_rd) r_dat_pipe[1] <= w_rd_data;
      for (int s = 2; s <= RD_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign bus.Q    = r_dat_pipe[RD_LAT];
  assign bus.QVLD = r_vld_pipe[RD_LAT];
  assign bus.BUSY = w_busy;
endmodule

// File: tb/tb_sram_sp_bwe_clr.sv
// Bench: latency-1 and latency-2 clearing SRAMs share stimulus, plus a
// no-clear instance watched for BUSY only.
module tb_sram_sp_bwe_clr;
  localparam int BITS = 64, DEPTH = 12, AW = 4, MW = 8;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   cyc = 0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_sp_bwe_clr_if #(.BITS(BITS), .ADDR_W(AW), .MASK_W(MW)) b1 ();
  sram_sp_bwe_clr_if #(.BITS(BITS), .ADDR_W(AW), .MASK_W(MW)) b2 ();
  sram_sp_bwe_clr_if #(.BITS(BITS), .ADDR_W(AW), .MASK_W(MW)) b3 ();

  sram_sp_bwe_clr #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(AW), .MASK_W(MW),
                    .RD_LAT(1), .CLR_ON_RST(1))
    dut1 (.CLK(clk), .RSTB(rstb), .bus(b1));
  sram_sp_bwe_clr #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(AW), .MASK_W(MW),
                    .RD_LAT(2), .CLR_ON_RST(1))
    dut2 (.CLK(clk), .RSTB(rstb), .bus(b2));
  sram_sp_bwe_clr #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(AW), .MASK_W(MW),
                    .RD_LAT(1), .CLR_ON_RST(0))
    dut3 (.CLK(clk), .RSTB(rstb), .bus(b3));

  typedef struct { logic [63:0] d; int due; } exp_t;
  typedef struct { bit rd; logic [3:0] a; logic [63:0] d; logic [7:0] bweb; logic [63:0] exp; } vec_t;

  exp_t        q1[$], q2[$];
  logic [63:0] mdl [DEPTH];
  logic [63:0] last_q1 = '0, last_q2 = '0;
  vec_t        tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: pop on QVLD, data and arrival cycle must both match
  always @(negedge clk) begin
    exp_t e;
    if (b1.QVLD) begin
      total++;
      if (q1.size() == 0) begin bad++; $display("FAIL qvld1_spurious: got Q=%h want no pulse", b1.Q); end
      else begin
        e = q1.pop_front();
        if (b1.Q !== e.d || cyc != e.due) begin
          bad++; $display("FAIL rd1: got %h@%0d want %h@%0d", b1.Q, cyc, e.d, e.due);
        end
        last_q1 = e.d;
      end
    end else if (q1.size() > 0 && q1[0].due < cyc) begin
      total++; bad++; e = q1.pop_front();
      $display("FAIL rd1_missing: got no QVLD want %h@%0d", e.d, e.due);
    end
    if (b2.QVLD) begin
      total++;
      if (q2.size() == 0) begin bad++; $display("FAIL qvld2_spurious: got Q=%h want no pulse", b2.Q); end
      else begin
        e = q2.pop_front();
        if (b2.Q !== e.d || cyc != e.due) begin
          bad++; $display("FAIL rd2: got %h@%0d want %h@%0d", b2.Q, cyc, e.d, e.due);
        end
        last_q2 = e.d;
      end
    end else if (q2.size() > 0 && q2[0].due < cyc) begin
      total++; bad++; e = q2.pop_front();
      $display("FAIL rd2_missing: got no QVLD want %h@%0d", e.d, e.due);
    end
  end

  task automatic set_bus(input logic ceb, input logic web, input logic [3:0] a,
                         input logic [63:0] d, input logic [7:0] bweb);
    b1.CEB = ceb; b1.WEB = web; b1.A = a; b1.D = d; b1.BWEB = bweb;
    b2.CEB = ceb; b2.WEB = web; b2.A = a; b2.D = d; b2.BWEB = bweb;
  endtask

  // one request per cycle; reads push expectations, writes update the model
  task automatic op(input bit rd, input logic [3:0] a, input logic [63:0] d,
                    input logic [7:0] bweb, input logic [63:0] exp);
    @(negedge clk); #1;
    set_bus(1'b0, rd, a, d, bweb);
    if (rd) begin
      q1.push_back('{d: exp, due: cyc + 1});
      q2.push_back('{d: exp, due: cyc + 2});
    end else if (a < DEPTH) begin
      for (int g = 0; g < MW; g++)
        if (!bweb[g]) mdl[a][g*8 +: 8] = d[g*8 +: 8];
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk); #1;
    set_bus(1'b1, 1'b1, '0, '0, '1);
    repeat (n) @(negedge clk);
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) op(1'b1, 4'(a), '0, '1, mdl[a]);
    idle(4);
  endtask

  // counts BUSY cycles from the first edge after release; optionally pokes
  // a write and a read while the clear runs
  task automatic busy_cnt(input bit poke, output int n1, output int n2, output int n3);
    n1 = 0; n2 = 0; n3 = 0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.BUSY) n1++;
      if (b2.BUSY) n2++;
      if (b3.BUSY) n3++;
      if (!b1.BUSY && !b2.BUSY) break;
      if (poke && i == 3) set_bus(1'b0, 1'b0, 4'd2, '1, 8'h00);
      if (poke && i == 5) set_bus(1'b0, 1'b1, 4'd2, '0, 8'hFF);
      if (poke && i == 7) set_bus(1'b1, 1'b1, 4'd0, '0, 8'hFF);
    end
  endtask

  initial begin
    int n1, n2, n3;
    tbl[0]  = '{0, 4'd3,  64'h1122334455667788, 8'h00, 64'h0};
    tbl[1]  = '{0, 4'd3,  64'hFFFFFFFFFFFFFFFF, 8'hF0, 64'h0};
    tbl[2]  = '{1, 4'd3,  64'h0,                8'hFF, 64'h11223344FFFFFFFF};
    tbl[3]  = '{0, 4'd5,  64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0};
    tbl[4]  = '{1, 4'd5,  64'h0,                8'hFF, 64'h0};
    tbl[5]  = '{0, 4'd13, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0};
    tbl[6]  = '{1, 4'd13, 64'h0,                8'hFF, 64'h0};
    tbl[7]  = '{0, 4'd7,  64'h0123456789ABCDEF, 8'h0F, 64'h0};
    tbl[8]  = '{1, 4'd7,  64'h0,                8'hFF, 64'h0123456700000000};
    tbl[9]  = '{0, 4'd11, 64'hCAFEBABE12345678, 8'h55, 64'h0};
    tbl[10] = '{1, 4'd11, 64'h0,                8'hFF, 64'hCA00BA0012005600};
    tbl[11] = '{1, 4'd0,  64'h0,                8'hFF, 64'h0};

    set_bus(1'b1, 1'b1, '0, '0, '1);
    b3.CEB = 1'b1; b3.WEB = 1'b1; b3.A = '0; b3.D = '0; b3.BWEB = '1;
    repeat (3) @(negedge clk);
    chk("rst_q1", b1.Q, 0);        chk("rst_q2", b2.Q, 0);
    chk("rst_qvld1", 64'(b1.QVLD), 0); chk("rst_qvld2", 64'(b2.QVLD), 0);
    chk("rst_busy1", 64'(b1.BUSY), 1); chk("rst_busy2", 64'(b2.BUSY), 1);
    chk("rst_busy3", 64'(b3.BUSY), 0);

    #1 rstb = 1'b1;
    busy_cnt(1'b1, n1, n2, n3);
    chk("busy_len1", 64'(n1), 12); chk("busy_len2", 64'(n2), 12);
    chk("busy_noclr", 64'(n3), 0);
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    sweep();
    chk("hold_q1", b1.Q, last_q1); chk("hold_q2", b2.Q, last_q2);

    for (int i = 0; i < 12; i++) op(tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].bweb, tbl[i].exp);
    idle(4);
    sweep();

    op(1'b0, 4'd1, 64'h1111000011110001, 8'h00, '0);
    op(1'b0, 4'd2, 64'h2222000022220002, 8'h00, '0);
    op(1'b0, 4'd3, 64'h3333000033330003, 8'h00, '0);
    op(1'b1, 4'd1, '0, '1, mdl[1]);
    op(1'b1, 4'd2, '0, '1, mdl[2]);
    op(1'b1, 4'd3, '0, '1, mdl[3]);
    idle(4);
    chk("hold_b2b", b2.Q, 64'h3333000033330003);

    @(negedge clk); #1 rstb = 1'b0;
    #1 chk("async_q1", b1.Q, 0); chk("async_q2", b2.Q, 0);
    @(negedge clk); #1 rstb = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #1 rstb = 1'b0;
    #1 chk("mid_busy", 64'(b1.BUSY), 1); chk("mid_qvld2", 64'(b2.QVLD), 0);
    @(negedge clk); #1 rstb = 1'b1;
    busy_cnt(1'b0, n1, n2, n3);
    chk("restart_len1", 64'(n1), 12); chk("restart_len2", 64'(n2), 12);
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    sweep();

    chk("sb1_empty", 64'(q1.size()), 0);
    chk("sb2_empty", 64'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_sp_bwe_clr.md
SRAM_SP_BWE_CLR -- requirements
Module: sram_sp_bwe_clr

Interface
REQ-001 The block SHALL have parameter BITS, default 128, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the word count; DEPTH need not be a power of two.
REQ-003 The block SHALL have parameter ADDR_W, default 3, giving the address width; ADDR_W >= clog2(DEPTH).
REQ-004 The block SHALL have parameter MASK_W, default 16, giving the write-mask width; BITS is a multiple of MASK_W, and each mask bit covers one group of BITS/MASK_W bits.
REQ-005 The block SHALL have parameter RD_LAT, default 1, giving the read latency in cycles; legal values are 1 and 2.
REQ-006 The block SHALL have parameter CLR_ON_RST, default 1; when 1, the whole array is zero-filled after reset.
REQ-007 CLK  input  1  single clock; all state changes on its rising edge.
REQ-008 RSTB  input  1  asynchronous, active-low reset.
REQ-009 CEB  input  1  chip enable, active low.
REQ-010 WEB  input  1  low = write, high = read; sampled only when CEB is low.
REQ-011 A  input  ADDR_W  word address.
REQ-012 D  input  BITS  write data.
REQ-013 BWEB  input  MASK_W  per-group write mask, active low.
REQ-014 Q  output  BITS  read data.
REQ-015 QVLD  output  1  one-cycle pulse, high in the same cycle Q carries new read data.
REQ-016 BUSY  output  1  high while the clear sequence runs; requests are ignored while BUSY is high.

Function
REQ-017 Write (CEB=0, WEB=0, BUSY=0, A<DEPTH): at the clock edge, only groups g with BWEB[g]=0 SHALL update to the matching D slice.
REQ-018 Read (CEB=0, WEB=1, BUSY=0): Q SHALL present ram[A] and QVLD SHALL be 1 exactly RD_LAT edges after the request edge.
REQ-019 RD_LAT=2: the data SHALL pass through one extra output register stage; back-to-back reads SHALL give back-to-back QVLD pulses.
REQ-020 When no read completes in a cycle, Q SHALL hold its last value (no randomisation) and QVLD SHALL be 0.
REQ-021 A >= DEPTH: a write SHALL be dropped; a read SHALL return all-zeros with QVLD=1.
REQ-022 A write followed by a read of the same address on the next cycle SHALL return the newly written data.
REQ-023 BWEB all-ones on a write SHALL leave memory unchanged; this counts as a legal no-op.
REQ-024 Clear FSM states: IDLE -> CLEAR -> DONE.
  - CLEAR writes zero to address cnt each cycle, cnt runs 0..DEPTH-1.
  - After the write to DEPTH-1, the FSM SHALL enter DONE.
REQ-025 BUSY SHALL be 1 in CLEAR and 0 in DONE; the clear takes exactly DEPTH cycles after the first edge following RSTB deassertion.
REQ-026 Requests with CEB=0 while BUSY=1 SHALL NOT modify memory and SHALL NOT produce QVLD.
REQ-027 CLR_ON_RST=0: the FSM SHALL go straight to DONE, BUSY SHALL stay 0, and array contents after reset are undefined.
REQ-028 A read already in the RD_LAT=2 pipe when a new request arrives SHALL complete normally.

Reset
REQ-029 RSTB low SHALL asynchronously force Q=0, QVLD=0, the pipeline valid bits to 0, cnt=0, and the state to IDLE.
REQ-030 During reset, BUSY SHALL equal CLR_ON_RST.
REQ-031 Reset asserted mid-CLEAR SHALL abort the sequence; the clear restarts from address 0 after release.
REQ-032 The memory array itself SHALL NOT be reset asynchronously.

Structure
REQ-033 The shared package sram_pkg SHALL hold:
  - the clear-FSM state enum;
  - the legal RD_LAT values;
  - a group-width helper constant function.
REQ-034 The clear FSM and address counter SHALL be the sub-module sram_clear_fsm; the array, mask merge and output pipe SHALL live in the top module.

Verification (BITS=64, DEPTH=12, ADDR_W=4, MASK_W=8)
REQ-035 Reset release, CLR_ON_RST=1 -> BUSY high for exactly 12 cycles; then reads of addresses 0..11 return 0 with QVLD=1.
REQ-036 Write A=3, D=0x1122334455667788, BWEB=0x00; then write A=3, D=all-ones, BWEB=0xF0; read A=3 -> Q=0x11223344FFFFFFFF.
REQ-037 RD_LAT=2, reads of A=1,2,3 on consecutive cycles -> three consecutive QVLD pulses starting 2 cycles after the first read, with data in order.
REQ-038 Write A=13 (out of range), then read A=13 -> Q=0 with QVLD=1, and addresses 0..11 are unchanged.
REQ-039 RSTB pulsed low at clear cycle 5 -> Q=0 immediately; after release, BUSY is high for a full 12 cycles.
REQ-040 Write request issued while BUSY=1 -> memory unchanged and the post-clear read returns 0.
